uart_rx: RTL

Serial receiver for the UART core, directly downstream of the baud clock generator. It oversamples the asynchronous `rx_i` line using a 16x-baud enable strobe and reconstructs 8N1 frames, LSB first, with optional parity. Received bytes are presented on a valid/ready handshake to the host-side logic, together with framing, parity and overrun error pulses.

---
 rtl/uart_rx.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver with valid/ready output and error pulses.
// Define UART_RX_PARITY_EN to add a parity bit between the data and stop bits.
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_tick_i,
    input  logic       rx_i,
    input  logic       parity_odd_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       parity_err_o,
    output logic       overrun_o
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            armed_q, armed_d;
    logic            rx_meta, rx_sync;
    logic            good_frame, frame_bad;
`ifdef UART_RX_PARITY_EN
    logic            perr_q, perr_d, parity_bad;
`else
    logic            unused_parity_odd;
    assign unused_parity_odd = parity_odd_i;
`endif

    // Both synchronizer stages reset high so reset never looks like a start bit
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            armed_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            armed_q <= armed_d;
`ifdef UART_RX_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        armed_d    = armed_q;
        good_frame = 1'b0;
        frame_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d     = perr_q;
        parity_bad = 1'b0;
`endif
        if (rx_tick_i) begin
            case (state_q)
                IDLE: begin
                    if (rx_sync) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        armed_d = 1'b0;
                        tick_d  = '0;
                        state_d = START;
                    end
                end
                START: begin
                    if (tick_q == MID) begin
                        if (!rx_sync) begin
                            state_d = DATA;
                            tick_d  = '0;
                            bit_d   = '0;
`ifdef UART_RX_PARITY_EN
                            perr_d  = 1'b0;
`endif
                        end else begin
                            armed_d = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                DATA: begin
                    tick_d = tick_q + TW'(1);
                    if (tick_q == LAST) begin
                        shift_d = {rx_sync, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    tick_d = tick_q + TW'(1);
                    if (tick_q == LAST) begin
                        perr_d  = rx_sync != (^shift_q ^ parity_odd_i);
                        state_d = STOP;
                    end
                end
`endif
                STOP: begin
                    tick_d = tick_q + TW'(1);
                    if (tick_q == LAST) begin
                        state_d = IDLE;
                        armed_d = rx_sync;
                        if (!rx_sync) begin
                            frame_bad = 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (perr_q) begin
                            parity_bad = 1'b1;
`endif
                        end else begin
                            good_frame = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A good frame may reload in the same cycle the old byte is consumed
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_o      <= 8'h00;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            frame_err_o <= frame_bad;
            overrun_o   <= 1'b0;
            if (good_frame && (!valid_o || ready_i)) begin
                data_o  <= shift_q;
                valid_o <= 1'b1;
            end else begin
                if (good_frame) begin
                    overrun_o <= 1'b1;
                end
                if (valid_o && ready_i) begin
                    valid_o <= 1'b0;
                end
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            parity_err_o <= 1'b0;
        end else begin
            parity_err_o <= parity_bad;
        end
    end
`else
    assign parity_err_o = 1'b0;
`endif

endmodule
